// File: rtl/dma_pkg.sv
// Shared definitions for the multi-channel DMA engine.
// Holds the register map offsets, CTRL bit positions and the engine FSM states.
package dma_pkg;

  localparam int unsigned SRC_OFS       = 'h0;
  localparam int unsigned DST_OFS       = 'h4;
  localparam int unsigned LEN_OFS       = 'h8;
  localparam int unsigned CTRL_OFS      = 'hC;
  localparam int unsigned CH_STRIDE     = 'h10;
  localparam int unsigned IRQ_STAT_ADDR = 'h100;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_BUSY  = 1;
  localparam int unsigned CTRL_DONE  = 2;
  localparam int unsigned CTRL_IRQEN = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_STEP
  } dma_state_e;

endpackage

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter for the DMA channels.
// Grants the first requester after the most recently served index.
module dma_rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              adv,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx
);

  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = IDX_W'((32'(last) + k) % NUM_CH);
      if (gnt == '0 && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= '0;
    end else if (adv) begin
      last <= idx;
    end
  end

endmodule

// File: rtl/dma_mc_engine.sv
// Multi-channel DMA engine: per-channel register file on the CPU bus and a
// single word-at-a-time memory master shared round-robin between channels.
module dma_mc_engine import dma_pkg::*; #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              irq
);

  localparam int unsigned       IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(DATA_W / 8);

  logic [ADDR_W-1:0] src [NUM_CH];
  logic [ADDR_W-1:0] dst [NUM_CH];
  logic [LEN_W-1:0]  len [NUM_CH];
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] irq_en;
  logic [NUM_CH-1:0] zpend;

  dma_state_e        state;
  dma_state_e        state_nxt;
  logic [IDX_W-1:0]  cur_ch;
  logic [IDX_W-1:0]  arb_idx;
  logic [NUM_CH-1:0] arb_gnt;
  logic              arb_adv;
  logic [DATA_W-1:0] rbuf;
  logic [DATA_W-1:0] rd_val;

  function automatic logic [ADDR_W-1:0] reg_addr(input int unsigned ch, input int unsigned ofs);
    return ADDR_W'(ch * CH_STRIDE + ofs);
  endfunction

  dma_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (busy),
    .adv   (arb_adv),
    .gnt   (arb_gnt),
    .idx   (arb_idx)
  );

  // Zero-length starts go through zpend so done rises one edge after the start write.
  // Engine updates come last so a done set overrides a same-cycle W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        src[c] <= '0;
        dst[c] <= '0;
        len[c] <= '0;
      end
      busy   <= '0;
      done   <= '0;
      irq_en <= '0;
      zpend  <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        zpend[c] <= 1'b0;
        if (wr_en && !busy[c]) begin
          if (addr == reg_addr(c, SRC_OFS)) src[c] <= ADDR_W'(wdata);
          if (addr == reg_addr(c, DST_OFS)) dst[c] <= ADDR_W'(wdata);
          if (addr == reg_addr(c, LEN_OFS)) len[c] <= LEN_W'(wdata);
        end
        if (wr_en && addr == reg_addr(c, CTRL_OFS)) begin
          irq_en[c] <= wdata[CTRL_IRQEN];
          if (wdata[CTRL_DONE]) done[c] <= 1'b0;
          if (wdata[CTRL_START] && !busy[c]) begin
            done[c] <= 1'b0;
            if (len[c] == '0) zpend[c] <= 1'b1;
            else              busy[c]  <= 1'b1;
          end
        end
        if (zpend[c]) done[c] <= 1'b1;
        if (state == ST_STEP && cur_ch == IDX_W'(c)) begin
          src[c] <= src[c] + STRIDE;
          dst[c] <= dst[c] + STRIDE;
          len[c] <= len[c] - LEN_W'(1);
          if (len[c] == LEN_W'(1)) begin
            busy[c] <= 1'b0;
            done[c] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rd_val = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (addr == reg_addr(c, SRC_OFS)) rd_val = DATA_W'(src[c]);
      if (addr == reg_addr(c, DST_OFS)) rd_val = DATA_W'(dst[c]);
      if (addr == reg_addr(c, LEN_OFS)) rd_val = DATA_W'(len[c]);
      if (addr == reg_addr(c, CTRL_OFS)) begin
        rd_val             = '0;
        rd_val[CTRL_BUSY]  = busy[c];
        rd_val[CTRL_DONE]  = done[c];
        rd_val[CTRL_IRQEN] = irq_en[c];
      end
    end
    if (addr == ADDR_W'(IRQ_STAT_ADDR)) rd_val = DATA_W'(done & irq_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_val;
    end
  end

  assign irq = |(done & irq_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cur_ch <= '0;
      rbuf   <= '0;
    end else begin
      state <= state_nxt;
      if (arb_adv) cur_ch <= arb_idx;
      if (state == ST_RD_WAIT && mem_rvalid) rbuf <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    arb_adv   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (|busy) state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (|arb_gnt) begin
          arb_adv   = 1'b1;
          state_nxt = ST_RD_REQ;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = src[cur_ch];
        if (mem_gnt) state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem_rvalid) state_nxt = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dst[cur_ch];
        mem_wdata = rbuf;
        if (mem_gnt) state_nxt = ST_STEP;
      end
      ST_STEP: begin
        state_nxt = ST_ARB;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dma_mc_engine.sv
// Scoreboard bench for dma_mc_engine: expected memory transactions are queued
// when channels are programmed and matched against the memory port as they appear.
module tb_dma_mc_engine;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        irq;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  txn_t        exp_wr[$];
  logic [31:0] exp_rd[$];
  int          wr_cyc[$];
  int          cyc;
  int          n_tests;
  int          n_fail;
  logic        stall;
  logic        req_seen;

  dma_mc_engine #(
    .NUM_CH (4),
    .ADDR_W (32),
    .DATA_W (32),
    .LEN_W  (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .wdata      (wdata),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Zero-wait memory unless stalled: grant in the request cycle, rvalid the cycle after.
  assign mem_gnt = mem_req & ~stall;

  always @(posedge clk) begin
    cyc        <= cyc + 1;
    mem_rvalid <= mem_req && mem_gnt && !mem_we;
    mem_rdata  <= data_of(mem_addr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_req) req_seen = 1'b1;
    if (rst_n && mem_req && mem_gnt) begin
      if (mem_we) begin
        chk("wr_expected", 64'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          txn_t t;
          t = exp_wr.pop_front();
          chk("wr_addr", mem_addr, t.a);
          chk("wr_data", mem_wdata, t.d);
        end
        wr_cyc.push_back(cyc);
      end else begin
        chk("rd_expected", 64'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) chk("rd_addr", mem_addr, exp_rd.pop_front());
      end
    end
  end

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic reg_rd(input logic [31:0] a, output logic [31:0] d);
    addr  = a;
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    d     = rdata;
  endtask

  task automatic push_word(input logic [31:0] s, input logic [31:0] d);
    txn_t t;
    exp_rd.push_back(s);
    t.a = d;
    t.d = data_of(s);
    exp_wr.push_back(t);
  endtask

  task automatic wait_idle(input int ch, output logic [31:0] v);
    v = 32'h2;
    for (int i = 0; i < 200; i++) begin
      reg_rd(32'(ch * 16 + 12), v);
      if (!v[1]) break;
    end
    chk($sformatf("idle_ch%0d", ch), v[1], 0);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50; i++) begin
      if (mem_req) break;
      @(posedge clk);
      #1;
    end
    chk("req_rise", mem_req, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    stall    = 1'b0;
    req_seen = 1'b0;
    rst_n    = 1'b0;
    addr     = '0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    wdata    = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset asserted in the middle of a read
    reg_wr(32'h0, 32'h55);
    addr  = 32'h0;
    rd_en = 1'b1;
    @(posedge clk);
    #1 chk("rd_pre_rst", rdata, 32'h55);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_irq", irq, 0);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    rst_n = 1'b1;
    reg_rd(32'hC, v);
    chk("rst_ctrl0", v, 0);
    reg_rd(32'h0, v);
    chk("rst_src0", v, 0);

    // Single three-word transfer on ch0
    reg_wr(32'h0, 32'h1000);
    reg_wr(32'h4, 32'h2000);
    reg_wr(32'h8, 3);
    for (int i = 0; i < 3; i++) push_word(32'h1000 + 32'(4 * i), 32'h2000 + 32'(4 * i));
    wr_cyc.delete();
    reg_wr(32'hC, 32'h1);
    wait_idle(0, v);
    chk("single_ctrl", v, 32'h4);
    chk("single_nwr", wr_cyc.size(), 3);
    if (wr_cyc.size() >= 2) chk("throughput", wr_cyc[1] - wr_cyc[0], 5);
    reg_rd(32'h8, v);
    chk("single_len", v, 0);
    reg_rd(32'h0, v);
    chk("single_src", v, 32'h100C);
    reg_rd(32'h4, v);
    chk("single_dst", v, 32'h200C);

    // Round-robin between ch1 and ch2
    reg_wr(32'h10, 32'h3000);
    reg_wr(32'h14, 32'h4000);
    reg_wr(32'h18, 2);
    reg_wr(32'h20, 32'h5000);
    reg_wr(32'h24, 32'h6000);
    reg_wr(32'h28, 2);
    push_word(32'h3000, 32'h4000);
    push_word(32'h5000, 32'h6000);
    push_word(32'h3004, 32'h4004);
    push_word(32'h5004, 32'h6004);
    reg_wr(32'h1C, 32'h1);
    reg_wr(32'h2C, 32'h1);
    wait_idle(1, v);
    wait_idle(2, v);
    chk("rr_ctrl2", v, 32'h4);
    reg_rd(32'h1C, v);
    chk("rr_ctrl1", v, 32'h4);

    // Zero-length start on ch3 with irq enabled
    req_seen = 1'b0;
    reg_wr(32'h3C, 32'h8);
    reg_wr(32'h3C, 32'h9);
    @(posedge clk);
    #1 chk("zl_irq", irq, 1);
    reg_rd(32'h3C, v);
    chk("zl_ctrl", v, 32'hC);
    reg_rd(32'h100, v);
    chk("zl_irq_stat", v, 32'h8);
    reg_wr(32'h3C, 32'hC);
    chk("zl_irq_clr", irq, 0);
    reg_rd(32'h3C, v);
    chk("zl_ctrl_clr", v, 32'h8);
    chk("zl_no_req", req_seen, 0);

    // Done set and W1C landing on the same edge
    reg_wr(32'h3C, 32'h9);
    reg_wr(32'h3C, 32'hC);
    reg_rd(32'h3C, v);
    chk("set_vs_w1c", v, 32'hC);
    chk("set_vs_w1c_irq", irq, 1);

    // Backpressure with address wrap, plus writes while busy
    stall = 1'b1;
    reg_wr(32'h0, 32'hFFFF_FFFC);
    reg_wr(32'h4, 32'h7000);
    reg_wr(32'h8, 2);
    push_word(32'hFFFF_FFFC, 32'h7000);
    push_word(32'h0000_0000, 32'h7004);
    reg_wr(32'hC, 32'h1);
    wait_req();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      chk("bp_req", mem_req, 1);
      chk("bp_addr", mem_addr, 32'hFFFF_FFFC);
    end
    reg_wr(32'h4, 32'h9990);
    reg_wr(32'hC, 32'h1);
    reg_rd(32'h4, v);
    chk("prot_dst", v, 32'h7000);
    reg_rd(32'h8, v);
    chk("prot_len", v, 2);
    reg_rd(32'hC, v);
    chk("prot_busy", v, 32'h2);
    stall = 1'b0;
    wait_idle(0, v);
    chk("bp_ctrl", v, 32'h4);
    reg_rd(32'h0, v);
    chk("bp_src", v, 32'h4);
    reg_rd(32'h4, v);
    chk("bp_dst", v, 32'h7008);
    chk("rd_q_empty", exp_rd.size(), 0);
    chk("wr_q_empty", exp_wr.size(), 0);

    // Reset while a request is pending
    stall = 1'b1;
    reg_wr(32'h10, 32'h100);
    reg_wr(32'h14, 32'h200);
    reg_wr(32'h18, 5);
    reg_wr(32'h1C, 32'h1);
    wait_req();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_addr", mem_addr, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stall = 1'b0;
    reg_rd(32'h18, v);
    chk("rst_mid_len", v, 0);
    reg_rd(32'h1C, v);
    chk("rst_mid_ctrl", v, 0);
    repeat (10) @(posedge clk);
    #1 chk("rst_mid_idle", mem_req, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
